// File: rtl/updown_step_scheduler.sv
// ----------------------------------------------------------------------------
// updown_step_scheduler
//
// Shares one 2-bit modulo-4 up/down counter between two requesters. A command
// (direction + step count) is accepted over valid/ready with round-robin
// arbitration when both requesters compete. The block then pulses step_en once
// per cycle for the requested number of steps while tracking where the counter
// should end up. It waits for the counter's registered output to settle,
// compares it with the tracked position, and reports completion with a
// match/mismatch flag.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_reqN_valid/dir/steps command from requester N (dir 0 = up, 1 = down)
//   o_reqN_ready          combinational; high only in IDLE for the granted one
//   i_pos_in              registered counter output {Q_B,Q_A}
//   o_step_en/o_step_dir  one counter step per high cycle of o_step_en
//   o_busy                command in progress
//   o_done/o_done_id/o_done_err  single-cycle completion report
//   o_expected_pos        tracked counter position
//   o_err_sticky/i_err_clr  sticky mismatch flag and its synchronous clear
// ----------------------------------------------------------------------------
module updown_step_scheduler #(
  parameter int STEP_W        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req0_valid,
  input  logic              i_req0_dir,
  input  logic [STEP_W-1:0] i_req0_steps,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic              i_req1_dir,
  input  logic [STEP_W-1:0] i_req1_steps,
  output logic              o_req1_ready,
  input  logic [1:0]        i_pos_in,
  output logic              o_step_en,
  output logic              o_step_dir,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_done_id,
  output logic              o_done_err,
  output logic [1:0]        o_expected_pos,
  output logic              o_err_sticky,
  input  logic              i_err_clr
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_rr;          // requester favoured when both are valid
  logic                r_id;
  logic [STEP_W-1:0]   r_steps_left;
  logic [SET_W-1:0]    r_settle_cnt;
  logic                r_step_en;
  logic                r_step_dir;
  logic                r_busy;
  logic                r_done;
  logic                r_done_id;
  logic                r_done_err;
  logic [1:0]          r_expected_pos;
  logic                r_err_sticky;

  logic                w_grant;
  logic                w_idle;
  logic                w_accept;
  logic                w_sel_dir;
  logic [STEP_W-1:0]   w_sel_steps;
  logic                w_check;
  logic                w_mismatch;

  // Next modulo-4 position after one step; both wraps fall out of 2-bit math.
  function automatic logic [1:0] f_step_pos(input logic [1:0] pos, input logic dir);
    logic [1:0] nxt;
    if (dir) begin
      nxt = pos - 2'd1;
    end else begin
      nxt = pos + 2'd1;
    end
    return nxt;
  endfunction

  // Grant selection: a lone valid wins, otherwise the round-robin pointer decides.
  always_comb begin
    w_grant = r_rr;
    if (i_req0_valid && !i_req1_valid) begin
      w_grant = 1'b0;
    end else if (i_req1_valid && !i_req0_valid) begin
      w_grant = 1'b1;
    end else begin
      w_grant = r_rr;
    end
  end

  // Command fields of the granted requester.
  always_comb begin
    w_sel_dir   = i_req0_dir;
    w_sel_steps = i_req0_steps;
    if (w_grant) begin
      w_sel_dir   = i_req1_dir;
      w_sel_steps = i_req1_steps;
    end else begin
      w_sel_dir   = i_req0_dir;
      w_sel_steps = i_req0_steps;
    end
  end

  assign w_idle       = (r_state == S_IDLE);
  assign o_req0_ready = w_idle & ~w_grant;
  assign o_req1_ready = w_idle & w_grant;
  assign w_accept     = (o_req0_ready & i_req0_valid) | (o_req1_ready & i_req1_valid);

  // The counter output is only trusted in the last settle cycle.
  assign w_check    = (r_state == S_SETTLE) && (r_settle_cnt == {SET_W{1'b0}});
  assign w_mismatch = w_check && (i_pos_in != r_expected_pos);

  // Command FSM with registered outputs and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rr           <= 1'b0;
      r_id           <= 1'b0;
      r_steps_left   <= {STEP_W{1'b0}};
      r_settle_cnt   <= {SET_W{1'b0}};
      r_step_en      <= 1'b0;
      r_step_dir     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_done_id      <= 1'b0;
      r_done_err     <= 1'b0;
      r_expected_pos <= 2'b00;
      r_err_sticky   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id       <= w_grant;
            r_rr       <= ~w_grant;
            r_busy     <= 1'b1;
            r_step_dir <= w_sel_dir;
            if (w_sel_steps != {STEP_W{1'b0}}) begin
              r_state      <= S_RUN;
              r_step_en    <= 1'b1;
              r_steps_left <= w_sel_steps;
            end else begin
              // Zero-step command still goes through the position check.
              r_state      <= S_SETTLE;
              r_settle_cnt <= SETTLE_LAST;
            end
          end
        end
        S_RUN: begin
          // Every RUN cycle is a step cycle; track the counter on its edge.
          r_expected_pos <= f_step_pos(r_expected_pos, r_step_dir);
          r_steps_left   <= r_steps_left - STEP_W'(1);
          if (r_steps_left == STEP_W'(1)) begin
            r_step_en    <= 1'b0;
            r_state      <= S_SETTLE;
            r_settle_cnt <= SETTLE_LAST;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == {SET_W{1'b0}}) begin
            r_state    <= S_REPORT;
            r_done     <= 1'b1;
            r_done_id  <= r_id;
            r_done_err <= w_mismatch;
          end else begin
            r_settle_cnt <= r_settle_cnt - SET_W'(1);
          end
        end
        S_REPORT: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_done_id  <= 1'b0;
          r_done_err <= 1'b0;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_step_en <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase

      // A mismatch seen in the same cycle as a clear request keeps the flag set.
      if (w_mismatch) begin
        r_err_sticky <= 1'b1;
      end else if (i_err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign o_step_en      = r_step_en;
  assign o_step_dir     = r_step_dir;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_done_id      = r_done_id;
  assign o_done_err     = r_done_err;
  assign o_expected_pos = r_expected_pos;
  assign o_err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_updown_step_scheduler.sv
// ----------------------------------------------------------------------------
// tb_updown_step_scheduler
//
// Drives directed and random step commands into updown_step_scheduler, hooks
// it to a modulo-4 counter with a two-cycle output latency, and checks every
// cycle against a transaction-level model: each accepted command is a window
// of N+SETTLE+1 cycles whose outputs follow from the cycle offset inside it.
// ----------------------------------------------------------------------------
module tb_updown_step_scheduler;

  localparam int STEP_W = 4;
  localparam int S      = 2;

  logic              clk;
  logic              reset;
  logic              req0_valid, req0_dir, req0_ready;
  logic [STEP_W-1:0] req0_steps;
  logic              req1_valid, req1_dir, req1_ready;
  logic [STEP_W-1:0] req1_steps;
  logic [1:0]        pos_in;
  logic              step_en, step_dir, busy, done, done_id, done_err, err_sticky;
  logic [1:0]        expected_pos;
  logic              err_clr;

  updown_step_scheduler #(.STEP_W(STEP_W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .i_req0_valid(req0_valid), .i_req0_dir(req0_dir), .i_req0_steps(req0_steps),
    .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_dir(req1_dir), .i_req1_steps(req1_steps),
    .o_req1_ready(req1_ready),
    .i_pos_in(pos_in),
    .o_step_en(step_en), .o_step_dir(step_dir), .o_busy(busy), .o_done(done),
    .o_done_id(done_id), .o_done_err(done_err), .o_expected_pos(expected_pos),
    .o_err_sticky(err_sticky), .i_err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter under control: steps on the edge after a step_en cycle, output
  // passes through one more register, optional fault flips output bits.
  logic [1:0] ctr_q, ctr_pipe, fault;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q    <= 2'd0;
      ctr_pipe <= 2'd0;
    end else begin
      if (step_en) ctr_q <= step_dir ? ctr_q - 2'd1 : ctr_q + 2'd1;
      ctr_pipe <= ctr_q;
    end
  end
  assign pos_in = ctr_pipe ^ fault;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int f_pos(input int start, input bit dir, input int k);
    int p;
    p = dir ? start - k : start + k;
    return ((p % 4) + 4) % 4;
  endfunction

  function automatic bit f_grant(input bit v0, input bit v1, input bit rr);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return rr;
  endfunction

  // ---------------- transaction-level model ----------------
  int cyc = 0;
  bit m_active, m_dir, m_id, m_rr, m_err, m_sticky, m_acc0, m_acc1, m_chk, m_idle, m_g;
  int m_c, m_n, m_start, m_pos, m_endpos;
  int m_done_cnt = 0;
  int dut_done_cnt = 0;

  task automatic model_reset();
    m_active = 0; m_rr = 0; m_pos = 0; m_sticky = 0; m_err = 0;
    m_acc0 = 0; m_acc1 = 0; m_c = 0; m_n = 0;
  endtask

  task automatic model_step();
    cyc++;
    m_idle = !m_active;
    m_g    = f_grant(req0_valid, req1_valid, m_rr);
    m_acc0 = m_idle && req0_valid && !m_g;
    m_acc1 = m_idle && req1_valid && m_g;
    m_endpos = f_pos(m_start, m_dir, m_n);
    m_chk = m_active && (m_c == m_n + S);
    if (m_chk) m_err = (int'(pos_in) != m_endpos);
    if (m_chk && m_err) m_sticky = 1;
    else if (err_clr) m_sticky = 0;
    if (m_active) begin
      m_c++;
      if (m_c == m_n + S + 1) m_done_cnt++;
      if (m_c > m_n + S + 1) begin
        m_active = 0;
        m_pos = m_endpos;
      end
    end
    if (m_acc0 || m_acc1) begin
      m_active = 1; m_c = 1; m_id = m_acc1; m_rr = !m_acc1; m_start = m_pos;
      m_n   = m_acc1 ? int'(req1_steps) : int'(req0_steps);
      m_dir = m_acc1 ? req1_dir : req0_dir;
    end
  endtask

  task automatic compare();
    bit e_step, e_done, e_idle, g;
    int e_pos;
    e_step = m_active && (m_c <= m_n);
    e_done = m_active && (m_c == m_n + S + 1);
    e_pos  = m_active ? f_pos(m_start, m_dir, (m_c - 1 < m_n) ? m_c - 1 : m_n) : m_pos;
    chk("busy", int'(busy), int'(m_active));
    chk("step_en", int'(step_en), int'(e_step));
    if (e_step) chk("step_dir", int'(step_dir), int'(m_dir));
    chk("done", int'(done), int'(e_done));
    if (e_done) begin
      chk("done_id", int'(done_id), int'(m_id));
      chk("done_err", int'(done_err), int'(m_err));
    end
    chk("expected_pos", int'(expected_pos), e_pos);
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
    e_idle = !m_active;
    g = f_grant(req0_valid, req1_valid, m_rr);
    if (req0_valid) chk("req0_ready", int'(req0_ready), int'(e_idle && !g));
    if (req1_valid) chk("req1_ready", int'(req1_ready), int'(e_idle && g));
    chk("ready_onehot", int'(req0_ready && req1_ready), 0);
    if (done) dut_done_cnt++;
  endtask

  // Model advances on every edge and compares 1 time unit later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else begin
        model_step();
        #1;
        if (!reset) compare();
      end
    end
  end

  // ---------------- directed helpers ----------------
  int acc_cyc;

  task automatic send(input int r, input bit d, input int n);
    bit got;
    @(negedge clk);
    if (r == 0) begin req0_valid = 1; req0_dir = d; req0_steps = STEP_W'(n); end
    else        begin req1_valid = 1; req1_dir = d; req1_steps = STEP_W'(n); end
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #2;
      got = (r == 0) ? m_acc0 : m_acc1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(negedge clk);
    if (r == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // Latency counts the cycle starting at the acceptance edge as cycle 1.
  task automatic wait_done(output int lat, output int id, output int err);
    bit seen;
    seen = 0; lat = -1; id = -1; err = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #2;
      if (done) begin
        seen = 1; lat = cyc - acc_cyc + 1; id = int'(done_id); err = int'(done_err);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  int lat, id, err, ids[4], nacc, dcnt;
  bit pend0, pend1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; err_clr = 0; fault = 2'b00;
    req0_valid = 0; req0_dir = 0; req0_steps = '0;
    req1_valid = 0; req1_dir = 0; req1_steps = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step_en", int'(step_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pos", int'(expected_pos), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_done_err", int'(done_err), 0);
    reset = 0;

    // 3 up from 0: done in cycle 3+2+1 = 6
    send(0, 0, 3); wait_done(lat, id, err);
    chk("up3_lat", lat, 6); chk("up3_id", id, 0); chk("up3_err", err, 0);
    chk("up3_pos", int'(expected_pos), 3);
    // 2 down from 3 -> 1
    send(1, 1, 2); wait_done(lat, id, err);
    chk("dn2_id", id, 1); chk("dn2_err", err, 0); chk("dn2_pos", int'(expected_pos), 1);
    // 1 -> 0 -> 3 (down wrap) -> 0 (up wrap)
    send(1, 1, 1); wait_done(lat, id, err); chk("dn1_pos", int'(expected_pos), 0);
    send(1, 1, 1); wait_done(lat, id, err);
    chk("wrap_dn_pos", int'(expected_pos), 3); chk("wrap_dn_err", err, 0);
    send(0, 0, 1); wait_done(lat, id, err);
    chk("wrap_up_pos", int'(expected_pos), 0); chk("wrap_up_err", err, 0);

    // Both valid: last grant went to req0, so order is 1,0,1,0
    @(negedge clk);
    req0_valid = 1; req0_dir = 0; req0_steps = 4'd1;
    req1_valid = 1; req1_dir = 0; req1_steps = 4'd1;
    nacc = 0;
    for (int i = 0; i < 200 && nacc < 4; i++) begin
      @(posedge clk); #2;
      if (m_acc0) begin ids[nacc] = 0; nacc++; end
      else if (m_acc1) begin ids[nacc] = 1; nacc++; end
    end
    @(negedge clk); req0_valid = 0; req1_valid = 0;
    chk("rr_count", nacc, 4);
    chk("rr_g0", ids[0], 1); chk("rr_g1", ids[1], 0);
    chk("rr_g2", ids[2], 1); chk("rr_g3", ids[3], 0);
    repeat (8) @(negedge clk);

    // Zero steps: done in cycle 3, no pulses
    send(0, 0, 0); wait_done(lat, id, err);
    chk("zero_lat", lat, 3); chk("zero_err", err, 0);
    // Off-by-one counter output
    fault = 2'b01;
    send(1, 0, 0); wait_done(lat, id, err);
    chk("fault_err", err, 1); chk("fault_id", id, 1); chk("fault_sticky", int'(err_sticky), 1);
    fault = 2'b00;
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("clr_sticky", int'(err_sticky), 0);
    // Clear held across a mismatch: the set wins
    fault = 2'b10; err_clr = 1;
    send(0, 0, 1); wait_done(lat, id, err);
    chk("clr_vs_set_err", err, 1); chk("clr_vs_set_sticky", int'(err_sticky), 1);
    @(negedge clk); fault = 2'b00;
    @(negedge clk); err_clr = 0;

    // Reset in the 2nd RUN cycle of a 5-step command
    send(0, 0, 5);
    @(negedge clk);
    reset = 1; #1;
    chk("abort_step_en", int'(step_en), 0);
    chk("abort_pos", int'(expected_pos), 0);
    chk("abort_busy", int'(busy), 0);
    dcnt = dut_done_cnt;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("abort_no_done", dut_done_cnt, dcnt);
    // 15 up from 0 -> 3
    send(0, 0, 15); wait_done(lat, id, err);
    chk("up15_lat", lat, 18); chk("up15_pos", int'(expected_pos), 3); chk("up15_err", err, 0);

    // Random traffic, each requester holds its command until accepted
    pend0 = 0; pend1 = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (pend0 && m_acc0) pend0 = 0;
      if (pend1 && m_acc1) pend1 = 0;
      if (!pend0 && ($urandom % 3 == 0)) begin
        pend0 = 1; req0_dir = 1'($urandom);
        req0_steps = STEP_W'(($urandom % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      end
      if (!pend1 && ($urandom % 3 == 0)) begin
        pend1 = 1; req1_dir = 1'($urandom);
        req1_steps = STEP_W'(($urandom % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      end
      req0_valid = pend0;
      req1_valid = pend1;
      fault   = ($urandom % 12 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      err_clr = ($urandom % 8 == 0);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; fault = 2'b00; err_clr = 0;
    repeat (30) @(negedge clk);
    chk("done_count", dut_done_cnt, m_done_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
